// File: rtl/axi4_burst_mgr_pkg.sv
// axi4_burst_mgr_pkg: shared FSM states, AXI response codes and the 4KB burst check
package axi4_burst_mgr_pkg;

   typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_REJ} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_REJ} r_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam int         KB4         = 4096;

   // A burst is legal when it fits the beat limit and ends at or before the next 4KB page.
   function automatic logic bnd_ok(input logic [11:0] off, input logic [7:0] len,
                                   input int bytes, input int max_len);
      int beats;
      beats = int'(len) + 1;
      return (beats <= max_len) && (int'(off) + beats * bytes <= KB4);
   endfunction

endpackage

// File: rtl/axi4_burst_mgr_if.sv
// AXI_BUS: AXI4 channel bundle with manager and subordinate views
interface AXI_BUS #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 9,
   parameter int AXI_USER_WIDTH = 5
);
   logic [AXI_ID_WIDTH-1:0]     aw_id, ar_id;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr, ar_addr;
   logic [7:0]                  aw_len, ar_len;
   logic [2:0]                  aw_size, ar_size, aw_prot, ar_prot;
   logic [1:0]                  aw_burst, ar_burst;
   logic                        aw_lock, ar_lock;
   logic [3:0]                  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
   logic [AXI_USER_WIDTH-1:0]   aw_user, ar_user, w_user;
   logic                        aw_valid, aw_ready, ar_valid, ar_ready;
   logic [AXI_DATA_WIDTH-1:0]   w_data, r_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last, w_valid, w_ready;
   logic [1:0]                  b_resp, r_resp;
   logic                        b_valid, b_ready;
   logic                        r_last, r_valid, r_ready;

   modport Manager (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
             aw_region, aw_user, aw_valid, w_data, w_strb, w_last, w_user, w_valid, b_ready,
             ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
             ar_region, ar_user, ar_valid, r_ready,
      input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_last, r_valid
   );

   modport Subordinate (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
             aw_region, aw_user, aw_valid, w_data, w_strb, w_last, w_user, w_valid, b_ready,
             ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
             ar_region, ar_user, ar_valid, r_ready,
      output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_last, r_valid
   );
endinterface

// File: rtl/axi4_4k_chk.sv
// axi4_4k_chk: combinational burst length and 4KB page-crossing check
module axi4_4k_chk
   import axi4_burst_mgr_pkg::*;
#(
   parameter int BYTES         = 8,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic [11:0] off_i,
   input  logic [7:0]  len_i,
   output logic        ok_o
);
   assign ok_o = bnd_ok(off_i, len_i, BYTES, MAX_BURST_LEN);
endmodule

// File: rtl/axi4_burst_mgr.sv
// axi4_burst_mgr: independent write and read INCR burst FSMs driving one AXI4 manager port
module axi4_burst_mgr
   import axi4_burst_mgr_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 9,
   parameter int AXI_USER_WIDTH = 5,
   parameter int MAX_BURST_LEN  = 16,
   parameter int WR_ID          = 0,
   parameter int RD_ID          = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      wr_req_i,
   input  logic [AXI_ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [7:0]                wr_len_i,
   output logic                      wr_ack_o,
   input  logic [AXI_DATA_WIDTH-1:0] wr_data_i,
   input  logic                      wr_data_valid_i,
   output logic                      wr_data_ready_o,
   output logic                      wr_done_o,
   output logic [1:0]                wr_err_o,
   output logic                      wr_bnd_err_o,
   input  logic                      rd_req_i,
   input  logic [AXI_ADDR_WIDTH-1:0] rd_addr_i,
   input  logic [7:0]                rd_len_i,
   output logic                      rd_ack_o,
   output logic [AXI_DATA_WIDTH-1:0] rd_data_o,
   output logic                      rd_data_valid_o,
   output logic                      rd_data_last_o,
   input  logic                      rd_data_ready_i,
   output logic                      rd_done_o,
   output logic [1:0]                rd_err_o,
   output logic                      rd_bnd_err_o,
   AXI_BUS.Manager                   axi_mgr_if
);
   localparam int BYTES = AXI_DATA_WIDTH / 8;
   localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN = ~AXI_ADDR_WIDTH'(BYTES - 1);

   w_state_e                  w_state_q;
   r_state_e                  r_state_q;
   logic [AXI_ADDR_WIDTH-1:0] w_addr_q, r_addr_q;
   logic [7:0]                w_len_q, r_len_q, w_cnt_q;
   logic                      wr_ok, rd_ok, w_hs, r_hs;
   logic                      wr_ack_q, wr_done_q, wr_bnd_q, rd_ack_q, rd_done_q, rd_bnd_q;
   logic [1:0]                wr_err_q, rd_err_q;

   axi4_4k_chk #(.BYTES(BYTES), .MAX_BURST_LEN(MAX_BURST_LEN)) u_wr_chk (
      .off_i(wr_addr_i[11:0]), .len_i(wr_len_i), .ok_o(wr_ok));
   axi4_4k_chk #(.BYTES(BYTES), .MAX_BURST_LEN(MAX_BURST_LEN)) u_rd_chk (
      .off_i(rd_addr_i[11:0]), .len_i(rd_len_i), .ok_o(rd_ok));

   assign w_hs = (w_state_q == W_DATA) && wr_data_valid_i && axi_mgr_if.w_ready;
   assign r_hs = (r_state_q == R_DATA) && axi_mgr_if.r_valid && rd_data_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_state_q <= W_IDLE;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         wr_ack_q  <= 1'b0;
         wr_done_q <= 1'b0;
         wr_bnd_q  <= 1'b0;
         wr_err_q  <= RESP_OKAY;
      end else begin
         wr_ack_q  <= 1'b0;
         wr_done_q <= 1'b0;
         wr_bnd_q  <= 1'b0;
         case (w_state_q)
            W_IDLE: if (wr_req_i) begin
               wr_ack_q  <= 1'b1;
               w_addr_q  <= wr_addr_i;
               w_len_q   <= wr_len_i;
               w_cnt_q   <= '0;
               wr_err_q  <= RESP_OKAY;
               w_state_q <= wr_ok ? W_ADDR : W_REJ;
            end
            W_ADDR: if (axi_mgr_if.aw_ready) w_state_q <= W_DATA;
            W_DATA: if (w_hs) begin
               w_cnt_q <= w_cnt_q + 8'd1;
               if (w_cnt_q == w_len_q) begin
                  w_cnt_q   <= '0;
                  w_state_q <= W_RESP;
               end
            end
            W_RESP: if (axi_mgr_if.b_valid) begin
               wr_err_q  <= axi_mgr_if.b_resp;
               wr_done_q <= 1'b1;
               w_state_q <= W_IDLE;
            end
            W_REJ: begin
               wr_done_q <= 1'b1;
               wr_bnd_q  <= 1'b1;
               w_state_q <= W_IDLE;
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state_q <= R_IDLE;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         rd_ack_q  <= 1'b0;
         rd_done_q <= 1'b0;
         rd_bnd_q  <= 1'b0;
         rd_err_q  <= RESP_OKAY;
      end else begin
         rd_ack_q  <= 1'b0;
         rd_done_q <= 1'b0;
         rd_bnd_q  <= 1'b0;
         case (r_state_q)
            R_IDLE: if (rd_req_i) begin
               rd_ack_q  <= 1'b1;
               r_addr_q  <= rd_addr_i;
               r_len_q   <= rd_len_i;
               rd_err_q  <= RESP_OKAY;
               r_state_q <= rd_ok ? R_ADDR : R_REJ;
            end
            R_ADDR: if (axi_mgr_if.ar_ready) r_state_q <= R_DATA;
            R_DATA: if (r_hs) begin
               rd_err_q <= (axi_mgr_if.r_resp > rd_err_q) ? axi_mgr_if.r_resp : rd_err_q;
               if (axi_mgr_if.r_last) begin
                  rd_done_q <= 1'b1;
                  r_state_q <= R_IDLE;
               end
            end
            R_REJ: begin
               rd_done_q <= 1'b1;
               rd_bnd_q  <= 1'b1;
               r_state_q <= R_IDLE;
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   assign wr_ack_o        = wr_ack_q;
   assign wr_done_o       = wr_done_q;
   assign wr_err_o        = wr_err_q;
   assign wr_bnd_err_o    = wr_bnd_q;
   assign wr_data_ready_o = (w_state_q == W_DATA) && axi_mgr_if.w_ready;
   assign rd_ack_o        = rd_ack_q;
   assign rd_done_o       = rd_done_q;
   assign rd_err_o        = rd_err_q;
   assign rd_bnd_err_o    = rd_bnd_q;
   assign rd_data_o       = (r_state_q == R_DATA) ? axi_mgr_if.r_data : '0;
   assign rd_data_valid_o = (r_state_q == R_DATA) && axi_mgr_if.r_valid;
   assign rd_data_last_o  = (r_state_q == R_DATA) && axi_mgr_if.r_last;

   assign axi_mgr_if.aw_id     = AXI_ID_WIDTH'(WR_ID);
   assign axi_mgr_if.aw_addr   = w_addr_q & ALIGN;
   assign axi_mgr_if.aw_len    = w_len_q;
   assign axi_mgr_if.aw_size   = 3'($clog2(BYTES));
   assign axi_mgr_if.aw_burst  = BURST_INCR;
   assign axi_mgr_if.aw_lock   = 1'b0;
   assign axi_mgr_if.aw_cache  = '0;
   assign axi_mgr_if.aw_prot   = '0;
   assign axi_mgr_if.aw_qos    = '0;
   assign axi_mgr_if.aw_region = '0;
   assign axi_mgr_if.aw_user   = '0;
   assign axi_mgr_if.aw_valid  = w_state_q == W_ADDR;
   // W is only live after the AW handshake, so WVALID cannot precede AWVALID/AWREADY.
   assign axi_mgr_if.w_data    = (w_state_q == W_DATA) ? wr_data_i : '0;
   assign axi_mgr_if.w_strb    = '1;
   assign axi_mgr_if.w_last    = (w_state_q == W_DATA) && (w_cnt_q == w_len_q);
   assign axi_mgr_if.w_user    = '0;
   assign axi_mgr_if.w_valid   = (w_state_q == W_DATA) && wr_data_valid_i;
   assign axi_mgr_if.b_ready   = w_state_q == W_RESP;
   assign axi_mgr_if.ar_id     = AXI_ID_WIDTH'(RD_ID);
   assign axi_mgr_if.ar_addr   = r_addr_q & ALIGN;
   assign axi_mgr_if.ar_len    = r_len_q;
   assign axi_mgr_if.ar_size   = 3'($clog2(BYTES));
   assign axi_mgr_if.ar_burst  = BURST_INCR;
   assign axi_mgr_if.ar_lock   = 1'b0;
   assign axi_mgr_if.ar_cache  = '0;
   assign axi_mgr_if.ar_prot   = '0;
   assign axi_mgr_if.ar_qos    = '0;
   assign axi_mgr_if.ar_region = '0;
   assign axi_mgr_if.ar_user   = '0;
   assign axi_mgr_if.ar_valid  = r_state_q == R_ADDR;
   assign axi_mgr_if.r_ready   = (r_state_q == R_DATA) && rd_data_ready_i;
endmodule
